dmem_arb2: RTL and testbench

Two-master arbiter for the shared data-memory bus. It sits between two requesters, port m0 (CPU data port) and port m1 (DMA or debug master), and the single upstream port of the address-decoding data-memory mux. It forwards one master's requests to the shared bus with round-robin fairness. It holds the grant across bursts and while any accepted access still awaits its ack, so every ack and read datum returns to the master that issued the access.

---
 rtl/dmem_arb2_pkg.sv | 25 ++
 rtl/dmem_outstanding_cnt.sv | 39 +++
 rtl/dmem_arb2.sv | 126 ++++++++++++
 tb/tb_dmem_arb2.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb2_pkg.sv
// Shared definitions for the two-master data-memory arbiter: bus field widths,
// master indices, the forwarded request bundle and the outstanding-counter width.
package dmem_arb2_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   wr;
    logic              rd;
    logic              burst;
  } bus_req_t;

  // Bits needed to hold 0..max_out inclusive.
  function automatic int cnt_w(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/dmem_outstanding_cnt.sv
// Up/down saturating count of accepted-but-unacked bus accesses, with full/zero
// flags and detection of acks that arrive while nothing is outstanding.
module dmem_outstanding_cnt
  import dmem_arb2_pkg::*;
#(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic ack,
  output logic zero,
  output logic full,
  output logic ack_ok,
  output logic stray
);

  localparam int CNT_W = cnt_w(int'(MAX));

  logic [CNT_W-1:0] cnt_q;

  assign zero   = (cnt_q == '0);
  assign full   = (cnt_q == CNT_W'(MAX));
  assign ack_ok = ack & ~zero;
  assign stray  = ack & zero;

  // An accept and a valid ack in the same cycle cancel; a stray ack never decrements.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc && !ack_ok && !full) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (!inc && ack_ok) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/dmem_arb2.sv
// Round-robin arbiter between two masters and one shared data-memory bus; the
// grant is held across bursts and while accesses are outstanding.
module dmem_arb2
  import dmem_arb2_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  input  logic [BE_W-1:0]   m0_wr_i,
  input  logic              m0_rd_i,
  input  logic              m0_burst_i,
  output logic              m0_accept_o,
  output logic              m0_ack_o,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  input  logic [BE_W-1:0]   m1_wr_i,
  input  logic              m1_rd_i,
  input  logic              m1_burst_i,
  output logic              m1_accept_o,
  output logic              m1_ack_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic [DATA_W-1:0] out_data_i,
  output logic [BE_W-1:0]   out_wr_o,
  output logic              out_rd_o,
  output logic              out_burst_o,
  input  logic              out_accept_i,
  input  logic              out_ack_i,
  output logic              busy_o,
  output logic              err_o
);

  bus_req_t m0_req, m1_req, sel_req, fwd_req;
  logic     m0_valid, m1_valid, sel_valid;
  logic     owner_q, last_q, burst_lock_q, err_q;
  logic     sel, lock, throttle, acc;
  logic     cnt_zero, cnt_full, ack_ok, stray;

  assign m0_req   = '{addr: m0_addr_i, data: m0_data_i, wr: m0_wr_i, rd: m0_rd_i, burst: m0_burst_i};
  assign m1_req   = '{addr: m1_addr_i, data: m1_data_i, wr: m1_wr_i, rd: m1_rd_i, burst: m1_burst_i};
  assign m0_valid = m0_rd_i | (|m0_wr_i);
  assign m1_valid = m1_rd_i | (|m1_wr_i);

  assign lock     = ~cnt_zero | burst_lock_q;
  assign throttle = cnt_full & ~out_ack_i;

  // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    sel = owner_q;
    if (!lock) begin
      if (m0_valid && !m1_valid)      sel = M0;
      else if (m1_valid && !m0_valid) sel = M1;
      else if (m0_valid && m1_valid)  sel = ~last_q;
    end
  end

  assign sel_req   = (sel == M1) ? m1_req : m0_req;
  assign sel_valid = (sel == M1) ? m1_valid : m0_valid;
  assign acc       = out_accept_i & sel_valid & ~throttle;

  // Idle masters drive nothing onto the bus; a full window masks only the strobes.
  always_comb begin
    fwd_req = '0;
    if (sel_valid) begin
      fwd_req = sel_req;
      if (throttle) begin
        fwd_req.rd = 1'b0;
        fwd_req.wr = '0;
      end
    end
  end

  assign out_addr_o  = fwd_req.addr;
  assign out_data_o  = fwd_req.data;
  assign out_wr_o    = fwd_req.wr;
  assign out_rd_o    = fwd_req.rd;
  assign out_burst_o = fwd_req.burst;

  assign m0_accept_o = acc & (sel == M0);
  assign m1_accept_o = acc & (sel == M1);

  // Responses follow the registered owner, which cannot change while accesses are in flight.
  assign m0_ack_o  = ack_ok & (owner_q == M0);
  assign m1_ack_o  = ack_ok & (owner_q == M1);
  assign m0_data_o = (owner_q == M0) ? out_data_i : '0;
  assign m1_data_o = (owner_q == M1) ? out_data_i : '0;

  assign busy_o = lock;
  assign err_o  = err_q;

  dmem_outstanding_cnt #(
    .MAX (MAX_OUTSTANDING)
  ) u_cnt (
    .clk    (clk_i),
    .rst_n  (rst_i),
    .inc    (acc),
    .ack    (out_ack_i),
    .zero   (cnt_zero),
    .full   (cnt_full),
    .ack_ok (ack_ok),
    .stray  (stray)
  );

  // last resets to m1 so that m0 wins the first contest.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      owner_q      <= M0;
      last_q       <= M1;
      burst_lock_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (acc) begin
        owner_q      <= sel;
        last_q       <= sel;
        burst_lock_q <= sel_req.burst;
      end
      if (stray) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_arb2.sv
// Directed bench for dmem_arb2: single access, round-robin alternation, burst
// lock, outstanding throttle, stray ack and reset in the middle of traffic.
module tb_dmem_arb2;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] m0_addr_i, m0_data_i, m0_data_o, m1_addr_i, m1_data_i, m1_data_o;
  logic [3:0]  m0_wr_i, m1_wr_i, out_wr_o;
  logic        m0_rd_i, m0_burst_i, m0_accept_o, m0_ack_o;
  logic        m1_rd_i, m1_burst_i, m1_accept_o, m1_ack_o;
  logic [31:0] out_addr_o, out_data_o, out_data_i;
  logic        out_rd_o, out_burst_o, out_accept_i, out_ack_i, busy_o, err_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_i = ~clk_i;

  dmem_arb2 #(.MAX_OUTSTANDING(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .m0_addr_i    (m0_addr_i),
    .m0_data_i    (m0_data_i),
    .m0_data_o    (m0_data_o),
    .m0_wr_i      (m0_wr_i),
    .m0_rd_i      (m0_rd_i),
    .m0_burst_i   (m0_burst_i),
    .m0_accept_o  (m0_accept_o),
    .m0_ack_o     (m0_ack_o),
    .m1_addr_i    (m1_addr_i),
    .m1_data_i    (m1_data_i),
    .m1_data_o    (m1_data_o),
    .m1_wr_i      (m1_wr_i),
    .m1_rd_i      (m1_rd_i),
    .m1_burst_i   (m1_burst_i),
    .m1_accept_o  (m1_accept_o),
    .m1_ack_o     (m1_ack_o),
    .out_addr_o   (out_addr_o),
    .out_data_o   (out_data_o),
    .out_data_i   (out_data_i),
    .out_wr_o     (out_wr_o),
    .out_rd_o     (out_rd_o),
    .out_burst_o  (out_burst_o),
    .out_accept_i (out_accept_i),
    .out_ack_i    (out_ack_i),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, act, exp, $time);
  endtask

  task automatic idle();
    m0_addr_i = '0; m0_data_i = '0; m0_wr_i = '0; m0_rd_i = 1'b0; m0_burst_i = 1'b0;
    m1_addr_i = '0; m1_data_i = '0; m1_wr_i = '0; m1_rd_i = 1'b0; m1_burst_i = 1'b0;
    out_data_i = '0; out_accept_i = 1'b0; out_ack_i = 1'b0;
  endtask

  // Inputs change just after a falling edge; outputs are sampled 1 ns later.
  task automatic next_cycle();
    @(negedge clk_i);
  endtask

  task automatic pulse_reset();
    idle();
    rst_i = 1'b0;
    #2;
    next_cycle();
    rst_i = 1'b1;
  endtask

  initial begin
    idle();
    #1;
    check("rst_m0_accept", m0_accept_o, 0);
    check("rst_m1_accept", m1_accept_o, 0);
    check("rst_m0_ack", m0_ack_o, 0);
    check("rst_m1_ack", m1_ack_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_err", err_o, 0);
    check("rst_out_addr", out_addr_o, 0);
    check("rst_out_rd", out_rd_o, 0);
    check("rst_m0_data", m0_data_o, 0);
    next_cycle();
    rst_i = 1'b1;

    // Single master read, acked two cycles after accept.
    next_cycle();
    m0_addr_i = 32'h1000_0004; m0_rd_i = 1'b1; out_accept_i = 1'b1;
    #1;
    check("single_out_addr", out_addr_o, 32'h1000_0004);
    check("single_out_rd", out_rd_o, 1);
    check("single_m0_accept", m0_accept_o, 1);
    check("single_m1_accept", m1_accept_o, 0);
    next_cycle();
    idle();
    #1;
    check("single_busy_wait", busy_o, 1);
    next_cycle();
    out_ack_i = 1'b1; out_data_i = 32'hDEAD_BEEF;
    #1;
    check("single_m0_ack", m0_ack_o, 1);
    check("single_m0_data", m0_data_o, 32'hDEAD_BEEF);
    check("single_m1_ack", m1_ack_o, 0);
    check("single_m1_data", m1_data_o, 0);
    next_cycle();
    idle();
    #1;
    check("single_cnt_zero", busy_o, 0);

    // Fairness: both masters request continuously; each grant is acked the following cycle.
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      m0_rd_i = 1'b1; m0_addr_i = 32'h0000_00A0;
      m1_rd_i = 1'b1; m1_addr_i = 32'h0000_00B0;
      out_accept_i = 1'b1; out_ack_i = 1'b0;
      #1;
      check($sformatf("fair_m0_accept_%0d", i), m0_accept_o, (i % 2 == 0) ? 1 : 0);
      check($sformatf("fair_m1_accept_%0d", i), m1_accept_o, (i % 2 == 1) ? 1 : 0);
      check($sformatf("fair_addr_%0d", i), out_addr_o, (i % 2 == 0) ? 32'hA0 : 32'hB0);
      next_cycle();
      out_accept_i = 1'b0; out_ack_i = 1'b1; out_data_i = 32'h100 + i;
      #1;
      check($sformatf("fair_m0_ack_%0d", i), m0_ack_o, (i % 2 == 0) ? 1 : 0);
      check($sformatf("fair_m1_ack_%0d", i), m1_ack_o, (i % 2 == 1) ? 1 : 0);
    end

    // Burst lock: m1 issues four beats while m0 requests from the second beat on.
    next_cycle();
    idle();
    m1_rd_i = 1'b1; m1_burst_i = 1'b1; m1_addr_i = 32'h200; out_accept_i = 1'b1;
    #1;
    check("burst_m1_accept_0", m1_accept_o, 1);
    check("burst_out_burst_0", out_burst_o, 1);
    for (int k = 1; k < 4; k++) begin
      next_cycle();
      m0_rd_i = 1'b1; m0_addr_i = 32'h300;
      m1_addr_i = 32'h200 + 4 * k; m1_burst_i = (k < 3);
      out_accept_i = 1'b1; out_ack_i = 1'b1; out_data_i = 32'h55 + k;
      #1;
      check($sformatf("burst_m0_blocked_%0d", k), m0_accept_o, 0);
      check($sformatf("burst_m1_accept_%0d", k), m1_accept_o, 1);
      check($sformatf("burst_m1_ack_%0d", k), m1_ack_o, 1);
      check($sformatf("burst_addr_%0d", k), out_addr_o, 32'h200 + 4 * k);
    end
    next_cycle();
    m1_rd_i = 1'b0; m1_burst_i = 1'b0;
    out_accept_i = 1'b1; out_ack_i = 1'b1;
    #1;
    check("burst_m0_blocked_last_ack", m0_accept_o, 0);
    check("burst_m1_last_ack", m1_ack_o, 1);
    check("burst_out_rd_idle", out_rd_o, 0);
    next_cycle();
    out_ack_i = 1'b0;
    #1;
    check("burst_m0_wins_after", m0_accept_o, 1);
    check("burst_m0_addr_after", out_addr_o, 32'h300);
    next_cycle();
    idle();
    out_ack_i = 1'b1;
    #1;
    check("burst_m0_ack_after", m0_ack_o, 1);

    // Throttle: four accepts fill the window, the fifth waits for an ack.
    next_cycle();
    idle();
    for (int i = 0; i < 4; i++) begin
      m0_rd_i = 1'b1; m0_addr_i = 32'h400 + 4 * i; out_accept_i = 1'b1;
      #1;
      check($sformatf("thr_accept_%0d", i), m0_accept_o, 1);
      next_cycle();
    end
    m0_addr_i = 32'h410;
    #1;
    check("thr_masked_rd", out_rd_o, 0);
    check("thr_masked_accept", m0_accept_o, 0);
    check("thr_masked_addr", out_addr_o, 32'h410);
    next_cycle();
    out_ack_i = 1'b1; out_data_i = 32'h0000_1234;
    #1;
    check("thr_unmask_rd", out_rd_o, 1);
    check("thr_unmask_accept", m0_accept_o, 1);
    check("thr_unmask_ack", m0_ack_o, 1);
    next_cycle();
    out_ack_i = 1'b0; m0_addr_i = 32'h414;
    #1;
    check("thr_still_full", out_rd_o, 0);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      idle();
      out_ack_i = 1'b1;
      #1;
      check($sformatf("thr_drain_ack_%0d", i), m0_ack_o, 1);
    end
    next_cycle();
    idle();
    #1;
    check("thr_drained", busy_o, 0);

    // Stray ack with nothing outstanding.
    next_cycle();
    out_ack_i = 1'b1; out_data_i = 32'hFFFF_0000;
    #1;
    check("stray_m0_ack", m0_ack_o, 0);
    check("stray_m1_ack", m1_ack_o, 0);
    check("stray_err_same_cycle", err_o, 0);
    next_cycle();
    idle();
    #1;
    check("stray_err_set", err_o, 1);
    next_cycle();
    next_cycle();
    #1;
    check("stray_err_sticky", err_o, 1);

    // Reset with two burst beats outstanding.
    next_cycle();
    m0_rd_i = 1'b1; m0_burst_i = 1'b1; m0_addr_i = 32'h500; out_accept_i = 1'b1;
    next_cycle();
    m0_addr_i = 32'h504;
    next_cycle();
    idle();
    #1;
    check("rstmid_busy_before", busy_o, 1);
    #1;
    rst_i = 1'b0;
    #1;
    check("rstmid_busy_cleared", busy_o, 0);
    check("rstmid_err_cleared", err_o, 0);
    next_cycle();
    rst_i = 1'b1;
    out_ack_i = 1'b1;
    #1;
    check("rstmid_old_ack_dropped", m0_ack_o, 0);
    next_cycle();
    idle();
    m0_rd_i = 1'b1; m0_addr_i = 32'h600;
    m1_rd_i = 1'b1; m1_addr_i = 32'h700;
    out_accept_i = 1'b1;
    #1;
    check("rstmid_old_ack_err", err_o, 1);
    check("rstmid_m0_wins", m0_accept_o, 1);
    check("rstmid_m1_loses", m1_accept_o, 0);
    check("rstmid_addr", out_addr_o, 32'h600);
    next_cycle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
